// File: rtl/mips_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : mips_instruction_fetch
// Description : Avalon-style instruction fetch responder. It runs one word read
//               per PC value, holds the instruction until decode consumes it,
//               and detects halt-address and misaligned fetches.
//               Optional byte swap of the fetched word: MIPS_FETCH_BSWAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_instruction_fetch #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    input  logic              instr_ack,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic [3:0]        byteenable,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              CntEn,
    output logic              active,
    output logic              fetch_fault
);

    localparam logic [3:0] c_BYTE_ENABLE = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_address;
    logic              r_read;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic              r_active;
    logic              r_fetch_fault;
    logic [31:0]       w_capture;

`ifdef MIPS_FETCH_BSWAP_EN
    // Big-endian instruction images on a little-endian bus.
    assign w_capture = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
`else
    assign w_capture = readdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_address     <= {ADDR_W{1'b0}};
            r_read        <= 1'b0;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_active      <= 1'b1;
            r_fetch_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_en) begin
                        if (pc == HALT_ADDR) begin
                            r_state  <= S_HALT;
                            r_active <= 1'b0;
                        end else if (pc[1:0] != 2'b00) begin
                            r_state       <= S_FAULT;
                            r_fetch_fault <= 1'b1;
                        end else begin
                            r_address <= pc;
                            r_read    <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // readdata is only ever sampled here, so stale responses
                    // after a reset cannot land in instr.
                    if (!waitrequest) begin
                        r_instr       <= w_capture;
                        r_read        <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_HALT, S_FAULT: begin
                    r_read        <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_read  <= 1'b0;
                end
            endcase
        end
    end

    assign address     = r_address;
    assign read        = r_read;
    assign byteenable  = c_BYTE_ENABLE;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign active      = r_active;
    assign fetch_fault = r_fetch_fault;
    // PC advances on the same edge that leaves HOLD.
    assign CntEn       = (r_state == S_HOLD) && instr_ack;

endmodule
`default_nettype wire

// File: tb/tb_mips_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_instruction_fetch
// Description : Directed self-checking bench for mips_instruction_fetch with a
//               transaction-level reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_en;
    logic        instr_ack;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        CntEn;
    logic        active;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    mips_instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .instr_ack   (instr_ack),
        .address     (address),
        .read        (read),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .CntEn       (CntEn),
        .active      (active),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expect_word(input logic [31:0] d);
`ifdef MIPS_FETCH_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Reference model: a transaction is either outstanding on the bus, waiting
    // for decode to take it, or the CPU has stopped for good.
    bit          m_outstanding, m_delivered, m_halted, m_faulted;
    logic [31:0] m_addr, m_instr;

    always @(posedge clk) begin
        if (rst) begin
            m_outstanding = 0; m_delivered = 0; m_halted = 0; m_faulted = 0;
            m_addr = 32'h0; m_instr = 32'h0;
        end else if (m_halted || m_faulted) begin
            // stopped until reset
        end else if (m_outstanding) begin
            if (!waitrequest) begin
                m_instr = expect_word(readdata);
                m_outstanding = 0;
                m_delivered = 1;
            end
        end else if (m_delivered) begin
            if (instr_ack) m_delivered = 0;
        end else if (fetch_en) begin
            if (pc == 32'h0)            m_halted = 1;
            else if (pc[1:0] != 2'b00)  m_faulted = 1;
            else begin
                m_addr = pc;
                m_outstanding = 1;
            end
        end
    end

    bit cmp_en = 0;
    int rd_cnt = 0;
    int cnt_pulses = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("address",     address,     m_addr);
            chk("read",        {31'h0, read},        {31'h0, m_outstanding});
            chk("byteenable",  {28'h0, byteenable},  32'hF);
            chk("instr",       instr,       m_instr);
            chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_delivered});
            chk("CntEn",       {31'h0, CntEn},       {31'h0, (m_delivered && instr_ack)});
            chk("active",      {31'h0, active},      {31'h0, !m_halted});
            chk("fetch_fault", {31'h0, fetch_fault}, {31'h0, m_faulted});
            if (read)  rd_cnt++;
            if (CntEn) cnt_pulses++;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1; pc = 32'h0; fetch_en = 0; instr_ack = 0; waitrequest = 0; readdata = 32'h0;
        cyc();
        cmp_en = 1;
        chk("rst_active", {31'h0, active}, 32'h1);
        chk("rst_read",   {31'h0, read},   32'h0);
        chk("rst_instr",  instr,           32'h0);
        rst = 0;
        cyc();

        // Zero-wait fetch
        pc = 32'hBFC00000; fetch_en = 1; waitrequest = 0; readdata = 32'h24020005; rd_cnt = 0;
        cyc();
        chk("t1_addr", address, 32'hBFC00000);
        fetch_en = 0;
        cyc();
        chk("t1_instr",  instr,  expect_word(32'h24020005));
        chk("t1_valid",  {31'h0, instr_valid}, 32'h1);
        chk("t1_rdcnt",  rd_cnt, 1);
        cnt_pulses = 0; instr_ack = 1;
        cyc();
        instr_ack = 0;
        cyc();
        chk("t1_pulses", cnt_pulses, 1);
        chk("t1_idle_valid", {31'h0, instr_valid}, 32'h0);

        // Three wait states, pc changes mid-wait
        pc = 32'hBFC00000; fetch_en = 1; waitrequest = 1; readdata = 32'hDEADBEEF; rd_cnt = 0;
        cyc();
        fetch_en = 0; pc = 32'h12345678;
        cyc(3);
        chk("t2_addr_wait", address, 32'hBFC00000);
        chk("t2_instr_wait", {31'h0, instr_valid}, 32'h0);
        waitrequest = 0; readdata = 32'h8C220004;
        cyc();
        chk("t2_rdcnt", rd_cnt, 4);
        chk("t2_instr", instr, expect_word(32'h8C220004));

        // Ack withheld for five cycles, then stray acks outside HOLD
        cnt_pulses = 0;
        cyc(5);
        chk("t3_no_pulse", cnt_pulses, 0);
        chk("t3_instr_hold", instr, expect_word(32'h8C220004));
        instr_ack = 1;
        cyc(3);
        instr_ack = 0;
        chk("t3_pulses", cnt_pulses, 1);

        // Byte-order check
        pc = 32'h00400000; fetch_en = 1; readdata = 32'h05000224;
        cyc();
        fetch_en = 0;
        cyc();
`ifdef MIPS_FETCH_BSWAP_EN
        chk("t5_bswap", instr, 32'h24020005);
`else
        chk("t5_plain", instr, 32'h05000224);
`endif
        instr_ack = 1;
        cyc();
        instr_ack = 0;

        // Halt address
        pc = 32'h00000000; fetch_en = 1; rd_cnt = 0;
        cyc(2);
        chk("t4_halted", {31'h0, active}, 32'h0);
        pc = 32'hBFC00000;
        cyc(3);
        chk("t4_still_halted", {31'h0, active}, 32'h0);
        chk("t4_no_read", rd_cnt, 0);
        fetch_en = 0; rst = 1;
        cyc();
        rst = 0;
        chk("t4_rst_active", {31'h0, active}, 32'h1);

        // Misaligned fetch
        pc = 32'hBFC00002; fetch_en = 1; rd_cnt = 0;
        cyc(2);
        chk("t6_fault", {31'h0, fetch_fault}, 32'h1);
        pc = 32'hBFC00000;
        cyc(3);
        chk("t6_sticky", {31'h0, fetch_fault}, 32'h1);
        chk("t6_no_read", rd_cnt, 0);
        fetch_en = 0; rst = 1;
        cyc();
        rst = 0;
        chk("t6_cleared", {31'h0, fetch_fault}, 32'h0);

        // Reset with a read outstanding
        pc = 32'hBFC00000; fetch_en = 1; waitrequest = 1;
        cyc();
        fetch_en = 0;
        chk("t7_read_req", {31'h0, read}, 32'h1);
        cyc();
        rst = 1;
        cyc();
        rst = 0; waitrequest = 0; readdata = 32'hDEADBEEF;
        chk("t7_read_drop", {31'h0, read}, 32'h0);
        cyc(2);
        chk("t7_instr", instr, 32'h0);
        chk("t7_valid", {31'h0, instr_valid}, 32'h0);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_instruction_fetch.md
Name: mips_instruction_fetch

Overview:
Responder side of the program-counter interface. It takes the current fetch address `pc` and runs one Avalon-style word read per instruction on the instruction memory bus, honouring `waitrequest`. It holds the fetched word for the decode/control stage and returns a one-cycle `CntEn` pulse so the PC advances only after the instruction is consumed. It also detects the halt address and misaligned fetches.

Parameters:
HALT_ADDR, 32'h00000000, fetch address that stops the CPU instead of issuing a read
ADDR_W, 32, width of pc and bus address

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous, active-high reset
pc  in  32  current fetch address from program counter
fetch_en  in  1  decode stage ready to start a fetch
instr_ack  in  1  decode stage consumed instr this cycle
address  out  32  bus word address
read  out  1  bus read strobe
byteenable  out  4  bus byte enables
waitrequest  in  1  bus stall; response valid when read && !waitrequest
readdata  in  32  bus read data
instr  out  32  fetched instruction word
instr_valid  out  1  instr holds a valid word
CntEn  out  1  PC advance strobe, one cycle
active  out  1  CPU running; low once halted
fetch_fault  out  1  misaligned fetch detected, sticky

Behaviour:
- Reset values: state IDLE, address=0, read=0, instr=0, instr_valid=0, active=1, fetch_fault=0. `CntEn` is 0 because it is combinational on state.
- `byteenable` is constant 4'b1111.
- States: IDLE, REQ, HOLD, HALT, FAULT.
- IDLE, fetch_en=0: remain in IDLE.
- IDLE, fetch_en=1, priority order:
  - pc==HALT_ADDR: go to HALT; active<=0.
  - pc[1:0]!=0: go to FAULT; fetch_fault<=1.
  - otherwise: address<=pc, read<=1, go to REQ.
- REQ, waitrequest=1: hold address and read unchanged. Changes on `pc` are ignored.
- REQ, waitrequest=0: instr<=readdata, read<=0, instr_valid<=1, go to HOLD.
- HOLD, instr_ack=0: hold instr and instr_valid. fetch_en is ignored.
- HOLD, instr_ack=1:
  - CntEn=1 combinationally in that cycle; the PC updates on the same edge.
  - instr_valid<=0; go to IDLE.
  - The first IDLE cycle therefore sees the updated pc.
- CntEn is high only when state==HOLD and instr_ack==1. Exactly one pulse per instruction.
- Minimum latency: fetch_en sampled at edge 0 → read=1 after edge 0 → zero-wait response sampled at edge 1 → instr_valid=1 after edge 1. Each waitrequest cycle adds one.
- instr_ack outside HOLD is ignored and produces no CntEn.
- HALT and FAULT are absorbing until rst. In both, read=0, instr_valid=0, CntEn=0.
- rst in any state, including REQ with read outstanding: returns to IDLE at that edge and read drops. Any response arriving after reset is ignored because readdata is sampled only in REQ.
- Address is registered; no combinational path from pc to address.

Optional Feature:
MIPS_FETCH_BSWAP_EN
- Defined: instr captures the byte-reversed word {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]}. This serves big-endian instruction images on a little-endian bus.
- Undefined: instr<=readdata unchanged.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset then pc=32'hBFC00000, fetch_en=1, waitrequest=0, readdata=32'h24020005 → read high for 1 cycle at address BFC00000. Then instr=24020005 and instr_valid=1. instr_ack=1 gives a single CntEn pulse; state returns to IDLE.
- Same fetch with waitrequest=1 for 3 cycles and pc changed to 32'h12345678 mid-wait → address stays BFC00000 with read high for 4 cycles. instr is captured only on the cycle with waitrequest=0.
- Valid instruction with instr_ack withheld 5 cycles → instr stable, CntEn=0 throughout. CntEn pulses once on the ack cycle.
- pc=32'h00000000, fetch_en=1 → no read; active=0 from the next cycle and stays 0 despite further fetch_en. rst restores active=1.
- pc=32'hBFC00002, fetch_en=1 → no read; fetch_fault=1 and sticky. rst clears it.
- rst asserted while in REQ with waitrequest=1, then waitrequest=0 with readdata=32'hDEADBEEF → read=0 after reset edge, instr=0, instr_valid=0.
- With MIPS_FETCH_BSWAP_EN, readdata=32'h05000224 → instr=32'h24020005.
